mod_counter: RTL and testbench
==============================

// Module: mod_counter
//
// PURPOSE
//   Parametrised successor to the fixed 22-bit free-running counter.
//   Adds a synchronous reset, clock enable, up/down direction and parallel load.
//   Adds a programmable modulus with either wrap or saturate behaviour.
//   A built-in prescaler makes one block cover blinkers, timers and event counters.
//   Sits between the board clock and LED/timer logic; the carry chain maps onto SB_CARRY/SB_LUT4.
//
// PARAMETERS
//   WIDTH       22         counter width in bits; 1..32
//   MODULUS     2**WIDTH   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   SATURATE    0          0: wrap at terminal count; 1: hold at terminal count
//   PRESCALE_W  8          width of the prescaler divide input DIV; 1..16
//
// PORTS
//   CLK    in   1            single clock; all state updates on its rising edge
//   RESET  in   1            synchronous, active-high reset
//   CE     in   1            count enable; gates the prescaler
//   UP     in   1            1: count up; 0: count down; sampled on each step
//   LD     in   1            synchronous parallel load of D
//   D      in   WIDTH        load value
//   DIV    in   PRESCALE_W   step every DIV+1 enabled cycles; 0 = every CE cycle
//   O      out  WIDTH        registered count value
//   COUT   out  1            registered one-cycle pulse on terminal-count step
//   TICK   out  1            registered one-cycle pulse per prescaler step (debug/chaining)
//
// BEHAVIOUR
//   - Reset: O=0, COUT=0, TICK=0, prescaler count P=0, all on the first edge with RESET=1.
//   - Priority per edge: RESET > LD > step > hold.
//   - Prescaler: P increments on CE=1. step = CE & (P >= DIV); on a step, P<=0.
//     - The >= compare makes a lowered DIV take effect immediately, with no long wrap.
//     - CE=0: P, O and TICK hold, and COUT=0.
//   - Step up (UP=1):
//     - O==MODULUS-1 is the terminal count: O<=0 (SATURATE=0) or O holds (SATURATE=1); COUT<=1.
//     - Otherwise O<=O+1.
//   - Step down (UP=0):
//     - O==0 is the terminal count: O<=MODULUS-1 (SATURATE=0) or O holds (SATURATE=1); COUT<=1.
//     - Otherwise O<=O-1.
//   - COUT and TICK:
//     - Latency: 1 cycle; COUT/TICK are asserted in the same cycle the new O is visible.
//     - Pulses last one cycle; back-to-back steps give back-to-back pulses (DIV=0, O at terminal, SATURATE=1).
//   - Load: LD=1 gives O<=D, P<=0, COUT<=0, TICK<=0; the load takes precedence over a coincident step.
//     - D >= MODULUS is clamped: O<=MODULUS-1.
//   - Arithmetic: +1/-1 is computed on WIDTH bits.
//     - With MODULUS==2**WIDTH the wrap is the natural carry-out, so the terminal compare reduces to the carry.
//     - No out-of-range O value is reachable.
//   - UP toggling mid-count: the new direction applies from the next step; no glitch and no extra pulse.
//   - RESET asserted mid-count or mid-prescale: all state clears on that edge, and the next step needs a full DIV+1 CE cycles.
//
// STRUCTURE
//   - Shared package mod_counter_pkg:
//     - DIR_UP/DIR_DOWN constants;
//     - MODE_WRAP/MODE_SAT constants;
//     - function clog2 for the checks.
//   - Sub-module tick_prescaler (CLK, RESET, CE, CLR=LD, DIV -> TICK_NEXT) holds P.
//   - Top holds O, COUT, TICK and the add/sub + terminal compare.
//   - Elaboration-time checks on MODULUS and WIDTH ranges.
//
// TESTING  (WIDTH=4, MODULUS=10, PRESCALE_W=4 unless noted)
//   1. Up wrap, SATURATE=0, DIV=0:
//      - stimulus: RESET, then CE=1, UP=1 for 12 cycles;
//      - response: O goes 1..9,0,1,2; COUT=1 only in the cycle O=0.
//   2. Down and saturate, SATURATE=1, DIV=0:
//      - stimulus: LD D=2, then UP=0 for 4 cycles;
//      - response: O goes 2,1,0,0,0; COUT high in each cycle O holds at 0.
//   3. Prescale, DIV=2:
//      - stimulus: CE=1 for 9 cycles;
//      - response: TICK on cycles 3,6,9; O=3. Drop CE for 4 cycles: O and P frozen.
//   4. Load clamp and priority:
//      - stimulus: LD=1, D=13, with a step due on the same edge;
//      - response: O=9, COUT=0, P=0. RESET+LD together give O=0.
//   5. Mid-operation reset:
//      - stimulus: O=7, P=1, DIV=3; then RESET for 1 cycle;
//      - response: O=0; the next TICK comes exactly 4 CE cycles later.
//   6. Default params (WIDTH=22):
//      - stimulus: preload 2**22-2, count up;
//      - response: O goes 2**22-1 then 0, with a single COUT pulse; O[21] falls.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants, step-action encoding and the elaboration-time clog2 helper
// for the modulo counter and its prescaler.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2
  } act_e;

  function automatic int clog2(input longint unsigned value);
    longint unsigned v;
    int r;
    r = 0;
    v = (value > 64'd0) ? value - 64'd1 : 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (v != 64'd0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Prescaler: counts enabled cycles in P and flags a counter step every DIV+1 of them.
// CLR (parallel load) restarts the prescale period just like RESET does.
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  CLR,
  input  logic [PRESCALE_W-1:0] DIV,
  output logic                  TICK_NEXT
);

  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] p_d;
  logic                  step;

  // A >= compare lets a lowered DIV take effect at once instead of waiting for P to wrap.
  always_comb begin
    step = CE && (p_q >= DIV);
    p_d  = p_q;
    if (CLR) begin
      p_d = '0;
    end else if (step) begin
      p_d = '0;
    end else if (CE) begin
      p_d = p_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign TICK_NEXT = step;

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, clock enable, prescaler,
// and wrap-or-saturate terminal behaviour.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH      = 22,
  parameter longint unsigned MODULUS    = 64'd1 << WIDTH,
  parameter int              SATURATE   = 0,
  parameter int              PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  UP,
  input  logic                  LD,
  input  logic [WIDTH-1:0]      D,
  input  logic [PRESCALE_W-1:0] DIV,
  output logic [WIDTH-1:0]      O,
  output logic                  COUT,
  output logic                  TICK
);

  localparam longint unsigned FULL_RANGE   = 64'd1 << WIDTH;
  localparam bit              NATURAL_WRAP = (MODULUS == FULL_RANGE);
  localparam logic [WIDTH-1:0] TERM_HI     = WIDTH'(MODULUS - 64'd1);
  localparam bit              SAT_EN       = (SATURATE == MODE_SAT);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be within 1..32");
  end
  if (MODULUS < 64'd2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be within 2..2**WIDTH");
  end
  if (PRESCALE_W < 1 || PRESCALE_W > 16) begin : g_bad_prescale
    $error("mod_counter: PRESCALE_W must be within 1..16");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("mod_counter: SATURATE must be 0 or 1");
  end

  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic             cout_q;
  logic             cout_d;
  logic             tick_q;
  logic             tick_d;
  logic             tick_next;
  logic [WIDTH:0]   inc_full;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] load_val;
  logic             term_up;
  logic             term_down;
  act_e             act;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE       (CE),
    .CLR      (LD),
    .DIV      (DIV),
    .TICK_NEXT(tick_next)
  );

  // At full range the terminal-count compare collapses onto the adder carry-out.
  assign inc_full  = {1'b0, o_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_val   = o_q - WIDTH'(1);
  assign term_up   = NATURAL_WRAP ? inc_full[WIDTH] : (o_q == TERM_HI);
  assign term_down = (o_q == '0);
  assign load_val  = (64'(D) >= MODULUS) ? TERM_HI : D;

  always_comb begin
    act = ACT_HOLD;
    if (LD) begin
      act = ACT_LOAD;
    end else if (tick_next) begin
      act = ACT_STEP;
    end
  end

  // With CE low TICK keeps its value; COUT is a pulse and always drops.
  always_comb begin
    o_d    = o_q;
    cout_d = 1'b0;
    tick_d = CE ? 1'b0 : tick_q;
    case (act)
      ACT_LOAD: begin
        o_d    = load_val;
        tick_d = 1'b0;
      end
      ACT_STEP: begin
        tick_d = 1'b1;
        case (UP)
          DIR_UP: begin
            if (term_up) begin
              cout_d = 1'b1;
              o_d    = SAT_EN ? o_q : '0;
            end else begin
              o_d = inc_full[WIDTH-1:0];
            end
          end
          DIR_DOWN: begin
            if (term_down) begin
              cout_d = 1'b1;
              o_d    = SAT_EN ? o_q : TERM_HI;
            end else begin
              o_d = dec_val;
            end
          end
          default: begin
            o_d = o_q;
          end
        endcase
      end
      default: begin
        o_d = o_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_q    <= '0;
      cout_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
      tick_q <= tick_d;
    end
  end

  assign O    = o_q;
  assign COUT = cout_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: two small counters (wrap and saturate, WIDTH=4, MODULUS=10)
// sharing one stimulus set, plus a default-parameter 22-bit counter.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, up, ld;
  logic [3:0] d, div;
  logic [3:0] oWrap, oSat;
  logic       coutWrap, tickWrap, coutSat, tickSat;

  logic        rstB, ceB, upB, ldB;
  logic [21:0] dB;
  logic [7:0]  divB;
  logic [21:0] oBig;
  logic        coutBig, tickBig;

  int vectorCount     = 0;
  int miscompareCount = 0;

  int t2SatO  [4] = '{1, 0, 0, 0};
  int t2SatC  [4] = '{0, 0, 1, 1};
  int t2WrapO [4] = '{1, 0, 9, 8};
  int t2WrapC [4] = '{0, 0, 1, 0};
  int t5Tick  [4] = '{0, 0, 0, 1};

  mod_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(0), .PRESCALE_W(4)) dutWrap (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LD(ld), .D(d), .DIV(div),
    .O(oWrap), .COUT(coutWrap), .TICK(tickWrap)
  );

  mod_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1), .PRESCALE_W(4)) dutSat (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LD(ld), .D(d), .DIV(div),
    .O(oSat), .COUT(coutSat), .TICK(tickSat)
  );

  mod_counter dutBig (
    .CLK(clk), .RESET(rstB), .CE(ceB), .UP(upB), .LD(ldB), .D(dB), .DIV(divB),
    .O(oBig), .COUT(coutBig), .TICK(tickBig)
  );

  task automatic checkOutput(input string tag, input longint unsigned got,
                             input longint unsigned expected);
    vectorCount++;
    if (got != expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic u, input logic l,
                               input logic [3:0] dv, input logic [3:0] dd);
    rst = r; ce = c; up = u; ld = l; d = dv; div = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic applyBigStimulus(input logic r, input logic c, input logic u, input logic l,
                                  input logic [21:0] dv);
    rstB = r; ceB = c; upB = u; ldB = l; dB = dv; divB = 8'd0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; up = 1'b1; ld = 1'b0; d = 4'd0; div = 4'd0;
    rstB = 1'b1; ceB = 1'b0; upB = 1'b1; ldB = 1'b0; dB = '0; divB = '0;

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    checkOutput("reset O", oWrap, 0);
    checkOutput("reset COUT", coutWrap, 0);
    checkOutput("reset TICK", tickWrap, 0);
    checkOutput("reset sat O", oSat, 0);

    $display("[TB] up count with wrap and saturate");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput($sformatf("up wrap O[%0d]", i), oWrap, (i + 1) % 10);
      checkOutput($sformatf("up wrap COUT[%0d]", i), coutWrap, ((i + 1) % 10 == 0) ? 1 : 0);
      checkOutput($sformatf("up wrap TICK[%0d]", i), tickWrap, 1);
      checkOutput($sformatf("up sat O[%0d]", i), oSat, (i + 1 > 9) ? 9 : i + 1);
      checkOutput($sformatf("up sat COUT[%0d]", i), coutSat, (i >= 9) ? 1 : 0);
    end

    $display("[TB] load then count down");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0);
    checkOutput("load sat O", oSat, 2);
    checkOutput("load sat COUT", coutSat, 0);
    checkOutput("load sat TICK", tickSat, 0);
    checkOutput("load wrap O", oWrap, 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      checkOutput($sformatf("down sat O[%0d]", i), oSat, t2SatO[i]);
      checkOutput($sformatf("down sat COUT[%0d]", i), coutSat, t2SatC[i]);
      checkOutput($sformatf("down wrap O[%0d]", i), oWrap, t2WrapO[i]);
      checkOutput($sformatf("down wrap COUT[%0d]", i), coutWrap, t2WrapC[i]);
    end

    $display("[TB] prescale by three");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
      checkOutput($sformatf("presc TICK[%0d]", i), tickWrap, (i % 3 == 2) ? 1 : 0);
    end
    checkOutput("presc O after 9", oWrap, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
    checkOutput("presc TICK p1", tickWrap, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2);
      checkOutput($sformatf("ce low O[%0d]", i), oWrap, 3);
      checkOutput($sformatf("ce low TICK[%0d]", i), tickWrap, 0);
      checkOutput($sformatf("ce low COUT[%0d]", i), coutWrap, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
    checkOutput("resume TICK 1", tickWrap, 0);
    checkOutput("resume O 1", oWrap, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
    checkOutput("resume TICK 2", tickWrap, 1);
    checkOutput("resume O 2", oWrap, 4);

    $display("[TB] load clamp and priority");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
    checkOutput("pre-load TICK", tickWrap, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 4'd2);
    checkOutput("clamp O", oWrap, 9);
    checkOutput("clamp COUT", coutWrap, 0);
    checkOutput("clamp TICK", tickWrap, 0);
    checkOutput("clamp sat O", oSat, 9);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
      checkOutput($sformatf("post-load TICK[%0d]", i), tickWrap, (i == 2) ? 1 : 0);
    end
    checkOutput("post-load wrap O", oWrap, 0);
    checkOutput("post-load wrap COUT", coutWrap, 1);
    checkOutput("post-load sat O", oSat, 9);
    checkOutput("post-load sat COUT", coutSat, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd2);
    checkOutput("reset+load O", oWrap, 0);
    checkOutput("reset+load sat O", oSat, 0);
    checkOutput("reset+load TICK", tickWrap, 0);

    $display("[TB] mid-operation reset");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd3);
    checkOutput("mid load O", oWrap, 7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd3);
    checkOutput("mid P1 TICK", tickWrap, 0);
    checkOutput("mid P1 O", oWrap, 7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd3);
    checkOutput("mid reset O", oWrap, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd3);
      checkOutput($sformatf("after reset TICK[%0d]", i), tickWrap, t5Tick[i]);
    end
    checkOutput("after reset O", oWrap, 1);

    $display("[TB] default 22-bit rollover");
    applyBigStimulus(1'b1, 1'b0, 1'b1, 1'b0, 22'd0);
    checkOutput("big reset O", oBig, 0);
    applyBigStimulus(1'b0, 1'b1, 1'b1, 1'b1, 22'h3FFFFE);
    checkOutput("big load O", oBig, 22'h3FFFFE);
    applyBigStimulus(1'b0, 1'b1, 1'b1, 1'b0, 22'd0);
    checkOutput("big max O", oBig, 22'h3FFFFF);
    checkOutput("big max COUT", coutBig, 0);
    checkOutput("big max O21", oBig[21], 1);
    applyBigStimulus(1'b0, 1'b1, 1'b1, 1'b0, 22'd0);
    checkOutput("big wrap O", oBig, 0);
    checkOutput("big wrap COUT", coutBig, 1);
    checkOutput("big wrap O21", oBig[21], 0);
    applyBigStimulus(1'b0, 1'b1, 1'b1, 1'b0, 22'd0);
    checkOutput("big next O", oBig, 1);
    checkOutput("big next COUT", coutBig, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
